// File: rtl/as_gpio_arb.sv
// Round-robin arbiter between the core (cpu) and debug (dbg) requesters for the GPIO slave port.
// Optional ack timeout is enabled by defining AS_GPIO_ARB_TIMEOUT_EN.
module as_gpio_arb #(
  parameter int unsigned DW      = 64,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_err_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_err_o,
  output logic          cs_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  input  logic [DW-1:0] rdata_i,
  input  logic          ack_i
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;
  localparam logic       IdCpu  = 1'b0;
  localparam logic       IdDbg  = 1'b1;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("as_gpio_arb: TIMEOUT must be in 2..255");
  end

  logic [0:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          owner_q, owner_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic          winner;
  logic          timeout;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    cs_d         = cs_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = '0;
    dbg_rdata_d  = '0;

    // On a tie the requester that did not win last time goes first.
    if (cpu_req_i && dbg_req_i) winner = ~rr_q;
    else if (dbg_req_i)         winner = IdDbg;
    else                        winner = IdCpu;

    case (state_q)
      StIdle: begin
        if (cpu_req_i || dbg_req_i) begin
          state_d = StBusy;
          cs_d    = 1'b1;
          owner_d = winner;
          rr_d    = winner;
          if (winner == IdDbg) begin
            we_d      = dbg_we_i;
            addr_d    = dbg_addr_i;
            wdata_d   = dbg_wdata_i;
            dbg_gnt_d = 1'b1;
          end else begin
            we_d      = cpu_we_i;
            addr_d    = cpu_addr_i;
            wdata_d   = cpu_wdata_i;
            cpu_gnt_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (ack_i || timeout) begin
          state_d = StIdle;
          cs_d    = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          // Writes and timeouts return zero data.
          if (owner_q == IdDbg) begin
            dbg_rvalid_d = 1'b1;
            if (ack_i && !we_q) dbg_rdata_d = rdata_i;
          end else begin
            cpu_rvalid_d = 1'b1;
            if (ack_i && !we_q) cpu_rdata_d = rdata_i;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      rr_q         <= IdDbg;
      owner_q      <= IdCpu;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

`ifdef AS_GPIO_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       cpu_err_q, dbg_err_q;

  // cnt_q holds the index (from 1) of the current BUSY cycle.
  assign timeout = (state_q == StBusy) && !ack_i && (cnt_q == TimeoutCnt);

  always_comb begin
    cnt_d = '0;
    if (state_q == StBusy && !ack_i && !timeout)           cnt_d = cnt_q + 8'd1;
    else if (state_q == StIdle && (cpu_req_i || dbg_req_i)) cnt_d = 8'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q     <= '0;
      cpu_err_q <= 1'b0;
      dbg_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cpu_err_q <= timeout && (owner_q == IdCpu);
      dbg_err_q <= timeout && (owner_q == IdDbg);
    end
  end

  assign cpu_err_o = cpu_err_q;
  assign dbg_err_o = dbg_err_q;
`else
  assign timeout   = 1'b0;
  assign cpu_err_o = 1'b0;
  assign dbg_err_o = 1'b0;
`endif

  assign cs_o         = cs_q;
  assign we_o         = we_q;
  assign addr_o       = addr_q;
  assign wdata_o      = wdata_q;
  assign cpu_gnt_o    = cpu_gnt_q;
  assign dbg_gnt_o    = dbg_gnt_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule

// File: tb/tb_as_gpio_arb.sv
// Bench for as_gpio_arb: transaction-level model checked every cycle, directed scenarios,
// then randomized requesters, slave acks and reset pulses.
module tb_as_gpio_arb;
  localparam int unsigned DW      = 64;
  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 16;
`ifdef AS_GPIO_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [DW-1:0] rdata = '0;
  logic          ack = 1'b0;
  logic          cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [DW-1:0] cpu_rdata, dbg_rdata, wdata_o;
  logic          cs_o, we_o;
  logic [AW-1:0] addr_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  as_gpio_arb #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .cs_o(cs_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata), .ack_i(ack)
  );

  // Transaction-level model: one open transaction record, last winner, busy age.
  int            m_owner;  // -1: no transaction, 0: cpu, 1: dbg
  int            m_last;
  int            m_age;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          e_cs, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd0, e_rd1;
  logic [1:0]    e_gnt, e_rv, e_err;

  task automatic m_reset();
    m_owner = -1; m_last = 1; m_age = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
  endtask

  task automatic m_finish(input bit err, input logic [DW-1:0] d);
    logic [DW-1:0] v;
    v = (err || m_we) ? '0 : d;
    e_rv[m_owner]  = 1'b1;
    e_err[m_owner] = err;
    if (m_owner == 0) e_rd0 = v; else e_rd1 = v;
    m_owner = -1;
  endtask

  task automatic m_step();
    logic [1:0] req;
    int w;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
    req = {dbg_req, cpu_req};
    if (m_owner >= 0) begin
      m_age++;
      if (ack) m_finish(1'b0, rdata);
      else if (ToEn && m_age == int'(TIMEOUT)) m_finish(1'b1, '0);
    end else if (req != 2'b00) begin
      if (req == 2'b11) w = 1 - m_last;
      else              w = req[1] ? 1 : 0;
      m_owner = w; m_last = w; m_age = 0; e_gnt[w] = 1'b1;
      if (w == 0) begin m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; end
      else        begin m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; end
    end
    e_cs    = (m_owner >= 0);
    e_we    = e_cs ? m_we : 1'b0;
    e_addr  = e_cs ? m_addr : '0;
    e_wdata = e_cs ? m_wdata : '0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset();
      else       m_step();
    end
  end

  wire [202:0] dut_vec = {cs_o, we_o, addr_o, wdata_o, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid,
                          cpu_err, dbg_err, cpu_rdata, dbg_rdata};
  wire [202:0] exp_vec = {e_cs, e_we, e_addr, e_wdata, e_gnt[0], e_gnt[1], e_rv[0], e_rv[1],
                          e_err[0], e_err[1], e_rd0, e_rd1};

  always @(negedge clk) begin
    if (rstn) begin
      n_chk++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL cycle_model t=%0t dut=%h expected=%h", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0; ack = 1'b0;
    repeat (2) tick();
    #2 rstn = 1'b1;
  endtask

  int            cnt;
  bit            seen;
  logic          got_err;
  logic [DW-1:0] got_rd;
  int            ack_mod;

  initial begin
    // Reset state.
    #2;
    chk("reset_outputs", DW'({cs_o, we_o, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err,
                             dbg_err}), '0);
    chk("reset_addr_wdata", DW'(addr_o) | wdata_o, '0);
    do_reset();

    // 1: cpu read of ID register, acked in first cs cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd0; ack = 1'b1; rdata = 64'h81;
    tick();
    chk("t1_gnt_cs", DW'({cpu_gnt, dbg_gnt, cs_o}), DW'(3'b101));
    cpu_req = 1'b0;
    tick();
    chk("t1_rvalid", DW'({cpu_rvalid, cpu_err, cs_o}), DW'(3'b100));
    chk("t1_rdata", cpu_rdata, 64'h81);
    ack = 1'b0;
    tick();
    chk("t1_rdata_hold0", DW'(cpu_rvalid) | cpu_rdata, '0);

    // 2: round-robin ties after reset.
    do_reset();
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0; ack = 1'b1; rdata = 64'h11;
    tick();
    chk("t2_first_cpu", DW'({cpu_gnt, dbg_gnt}), DW'(2'b10));
    cpu_req = 1'b0; rdata = 64'h22;
    tick();
    chk("t2_cpu_done", DW'({cpu_rvalid, dbg_gnt}), DW'(2'b10));
    tick();
    chk("t2_then_dbg", DW'({cpu_gnt, dbg_gnt}), DW'(2'b01));
    dbg_req = 1'b0;
    tick();
    chk("t2_dbg_rdata", dbg_rdata, 64'h22);
    cpu_req = 1'b1; dbg_req = 1'b1;
    tick();
    chk("t2_third_cpu", DW'({cpu_gnt, dbg_gnt}), DW'(2'b10));
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    ack = 1'b0;
    tick();

    // 3: dbg write, ack delayed 3 cycles.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd2; dbg_wdata = 64'hA5; rdata = 64'hDEAD;
    tick();
    dbg_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_strobes", DW'({cs_o, we_o, addr_o}) ^ wdata_o, DW'({1'b1, 1'b1, 3'd2}) ^ 64'hA5);
      chk("t3_cpu_quiet", DW'({cpu_gnt, cpu_rvalid, dbg_rvalid}), '0);
      if (i == 3) ack = 1'b1;
      tick();
    end
    chk("t3_done", DW'({dbg_rvalid, cs_o, cpu_rvalid}), DW'(3'b100));
    chk("t3_wr_rdata0", dbg_rdata, '0);
    ack = 1'b0;
    tick();

    // 4: reset during BUSY aborts at once.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd1;
    tick();
    cpu_req = 1'b0;
    tick();
    #1 rstn = 1'b0;
    #1 chk("t4_abort", DW'({cs_o, cpu_gnt, cpu_rvalid, dbg_rvalid}), '0);
    #1 rstn = 1'b1;
    tick();
    chk("t4_no_rvalid", DW'({cs_o, cpu_rvalid}), '0);
    cpu_req = 1'b1; ack = 1'b1; rdata = 64'h77;
    tick();
    chk("t4_regrant", DW'(cpu_gnt), 64'h1);
    cpu_req = 1'b0;
    tick();
    chk("t4_rdata", DW'(cpu_rvalid) ^ cpu_rdata, 64'h76);
    ack = 1'b0;

    // 6: ack in IDLE is ignored.
    tick();
    ack = 1'b1;
    repeat (2) begin
      tick();
      chk("t6_idle_ack", DW'({cs_o, cpu_rvalid, dbg_rvalid}), '0);
    end
    ack = 1'b0;

    // 5: slave never acks.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd3; rdata = 64'h99;
    tick();
    cpu_req = 1'b0;
    cnt = 0; seen = 1'b0; got_err = 1'b0; got_rd = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (cs_o) cnt++;
      if (cpu_rvalid) begin
        seen = 1'b1; got_err = cpu_err; got_rd = cpu_rdata;
      end else begin
        tick();
      end
    end
    if (ToEn) begin
      chk("t5_timeout_seen", DW'(seen), 64'h1);
      chk("t5_cs_cycles", DW'(cnt), 64'd16);
      chk("t5_err_rdata", DW'(got_err) ^ got_rd, 64'h1);
      tick();
      // ack in the final allowed cycle completes normally.
      cpu_req = 1'b1;
      tick();
      cpu_req = 1'b0;
      repeat (15) tick();
      ack = 1'b1; rdata = 64'h66;
      tick();
      chk("t5_last_cycle_ack", DW'({cpu_rvalid, cpu_err}), DW'(2'b10));
      chk("t5_last_cycle_rdata", cpu_rdata, 64'h66);
    end else begin
      chk("t5_still_waiting", DW'({seen, cs_o}), DW'(2'b01));
      chk("t5_cs_cycles", DW'(cnt), 64'd40);
      ack = 1'b1; rdata = 64'h55;
      tick();
      chk("t5_late_ack", DW'({cpu_rvalid, cpu_err}), DW'(2'b10));
      chk("t5_late_rdata", cpu_rdata, 64'h55);
    end
    ack = 1'b0;
    tick();

    // Randomized traffic.
    ack_mod = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) ack_mod = int'($urandom_range(1, 6));
      if (cpu_req && e_gnt[0])                       cpu_req = 1'b0;
      else if (cpu_req && $urandom_range(0, 15) == 0) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = AW'($urandom);
        cpu_wdata = {$urandom, $urandom};
      end
      if (dbg_req && e_gnt[1])                       dbg_req = 1'b0;
      else if (dbg_req && $urandom_range(0, 15) == 0) dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom); dbg_addr = AW'($urandom);
        dbg_wdata = {$urandom, $urandom};
      end
      ack   = ($urandom_range(0, ack_mod - 1) == 0);
      rdata = {$urandom, $urandom};
      if ($urandom_range(0, 399) == 0) begin
        #1 rstn = 1'b0;
        #1 rstn = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
